// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: three-stage pipelined carry-lookahead add/subtract unit with ready/valid handshake
//   clk, rst              : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     : operand beat handshake (in_ready = pipeline may advance)
//   a, b, cin, sub        : operands; sub=0 -> a+b+cin, sub=1 -> a-b-cin
//   out_valid/out_ready   : result handshake
//   sum, cout, ovf, zero  : result, carry-out (NOT borrow on sub), signed overflow, sum==0
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NG = WIDTH / GROUP;
  if (WIDTH % GROUP != 0 || WIDTH < 4) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and at least 4");
  end
  logic             advance;
  logic [WIDTH-1:0] bp_d, p_d, g_d;
  logic             c0_d;
  logic             v1_q, c0_q;
  logic [WIDTH-1:0] p1_q, g1_q;
  logic [NG-1:0]    gp, gg;
  logic [NG:0]      gc;
  logic [WIDTH:0]   c_d;
  logic             v2_q;
  logic [WIDTH-1:0] p2_q;
  logic [WIDTH:0]   c2_q;
  logic [WIDTH-1:0] sum_d;
  logic             v3_q, cout_q, ovf_q, zero_q;
  logic [WIDTH-1:0] sum_q;
  // Every stage shifts together; a full output stage that is not being taken freezes the whole pipe.
  assign advance  = !v3_q | out_ready;
  assign in_ready = advance;
  // Subtraction is folded into b' and c0, so nothing downstream needs to know the mode.
  assign bp_d = sub ? ~b : b;
  assign c0_d = sub ? ~cin : cin;
  assign p_d  = a ^ bp_d;
  assign g_d  = a & bp_d;
  always_comb begin
    gp = '0;
    gg = '0;
    gc = '0;
    c_d = '0;
    gc[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      logic acc;
      acc = 1'b0;
      for (int j = 0; j < GROUP; j++) acc = g1_q[k*GROUP+j] | (p1_q[k*GROUP+j] & acc);
      gg[k] = acc;
      gp[k] = &p1_q[k*GROUP +: GROUP];
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // In-group carries start from each group's lookahead carry-in, so no chain crosses a group boundary.
    for (int k = 0; k < NG; k++) begin
      logic cr;
      cr = gc[k];
      for (int j = 0; j < GROUP; j++) begin
        c_d[k*GROUP+j] = cr;
        cr = g1_q[k*GROUP+j] | (p1_q[k*GROUP+j] & cr);
      end
    end
    c_d[WIDTH] = gc[NG];
  end
  assign sum_d = p2_q ^ c2_q[WIDTH-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      c0_q   <= 1'b0;
      p1_q   <= '0;
      g1_q   <= '0;
      v2_q   <= 1'b0;
      p2_q   <= '0;
      c2_q   <= '0;
      v3_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      v1_q   <= in_valid;
      c0_q   <= c0_d;
      p1_q   <= p_d;
      g1_q   <= g_d;
      v2_q   <= v1_q;
      p2_q   <= p1_q;
      c2_q   <= c_d;
      v3_q   <= v2_q;
      sum_q  <= sum_d;
      cout_q <= c2_q[WIDTH];
      ovf_q  <= c2_q[WIDTH] ^ c2_q[WIDTH-1];
      zero_q <= ~|sum_d;
    end
  end
  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed and randomized checks of cla_pipe_adder at 16/4, 8/4 and 32/8
module tb_cla_pipe_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
  logic [15:0] a, b, sum;
  logic        r_in_valid, r_out_ready, r_cin, r_sub;
  logic        in_ready8, out_valid8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, sum8;
  logic        in_ready32, out_valid32, cout32, ovf32, zero32;
  logic [31:0] a32, b32, sum32;
  int errors = 0;
  int checks = 0;
  typedef struct {
    longint s;
    bit     co;
    bit     ov;
    bit     z;
  } exp_t;
  exp_t q8[$];
  exp_t q32[$];
  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));
  cla_pipe_adder #(.WIDTH(8), .GROUP(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(in_ready8), .a(a8), .b(b8),
    .cin(r_cin), .sub(r_sub), .out_valid(out_valid8), .out_ready(r_out_ready),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .zero(zero8));
  cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(in_ready32), .a(a32), .b(b32),
    .cin(r_cin), .sub(r_sub), .out_valid(out_valid32), .out_ready(r_out_ready),
    .sum(sum32), .cout(cout32), .ovf(ovf32), .zero(zero32));
  // Behavioural reference: exact signed/unsigned arithmetic in 64 bits, then reduced mod 2^w.
  function automatic void model(input int w, input longint ua, input longint ub, input bit ci,
                                input bit sb, output longint s, output bit co, output bit ov,
                                output bit z);
    longint half, sa, sbv, r;
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sbv  = (ub >= half) ? ub - 2 * half : ub;
    r    = sb ? sa - sbv - longint'(ci) : sa + sbv + longint'(ci);
    ov   = (r >= half) || (r < -half);
    co   = sb ? (ua >= ub + longint'(ci)) : (ua + ub + longint'(ci) >= 2 * half);
    s    = r & (2 * half - 1);
    z    = (s == 0);
  endfunction
  task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                          input logic ts, output int lat);
    @(negedge clk);
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    int lat;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf, zero, in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b sum=%h cout=%b ovf=%b zero=%b in_ready=%b, want 0 0000 0 0 0 1",
               out_valid, sum, cout, ovf, zero, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100 + 16'(i); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, sum} !== {1'b1, 16'h0101}) begin
      errors++;
      $display("FAIL prereset_stream: out_valid=%b sum=%h, want 1 0101", out_valid, sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sum} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b sum=%h, want 0 0000", out_valid, sum);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, sum} !== {1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_hold: out_valid=%b sum=%h, want 0 0000", out_valid, sum);
    end
    rst = 1'b0;
    run_beat(16'h1234, 16'h1111, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL latency: got %0d cycles, want 3", lat);
    end
    checks++;
    if ({sum, cout, ovf, zero} !== {16'h2345, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_add: sum=%h cout=%b ovf=%b zero=%b, want 2345 0 0 0", sum, cout, ovf, zero);
    end
  endtask
  task automatic test_carry_chain;
    int lat;
    run_beat(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat);
    checks++;
    if ({lat == 3, sum, cout, ovf, zero} !== {1'b1, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL carry_chain: lat=%0d sum=%h cout=%b ovf=%b zero=%b, want 3 0000 1 0 1", lat, sum, cout, ovf, zero);
    end
  endtask
  task automatic test_overflow;
    int lat;
    run_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++;
    if ({lat == 3, sum, cout, ovf, zero} !== {1'b1, 16'h8000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_add: lat=%0d sum=%h cout=%b ovf=%b zero=%b, want 3 8000 0 1 0", lat, sum, cout, ovf, zero);
    end
    run_beat(16'h8000, 16'h0001, 1'b0, 1'b1, lat);
    checks++;
    if ({lat == 3, sum, cout, ovf, zero} !== {1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_sub: lat=%0d sum=%h cout=%b ovf=%b zero=%b, want 3 7fff 1 1 0", lat, sum, cout, ovf, zero);
    end
  endtask
  task automatic test_borrow;
    int lat;
    run_beat(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    checks++;
    if ({lat == 3, sum, cout, ovf, zero} !== {1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL borrow: lat=%0d sum=%h cout=%b ovf=%b zero=%b, want 3 fffd 0 0 0", lat, sum, cout, ovf, zero);
    end
  endtask
  task automatic test_back_to_back;
    logic [15:0] va[5] = '{16'h0001, 16'h00FF, 16'h7FFF, 16'hFFFF, 16'h1234};
    logic [15:0] vb[5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h4321};
    logic [15:0] es[5] = '{16'h0002, 16'h0100, 16'h8000, 16'h0000, 16'h5555};
    logic [3:0]  eco = 4'b0000;
    logic [4:0]  ec = 5'b01000;
    logic [4:0]  eo = 5'b00100;
    logic [4:0]  ez = 5'b01000;
    int sent = 0, got = 0, hold = 0, cyc = 0;
    bit started = 0;
    while (got < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !started) begin
        started = 1;
        hold = 4;
      end
      out_ready = (hold == 0);
      in_valid = (sent < 5);
      a = va[sent % 5]; b = vb[sent % 5]; cin = 1'b0; sub = 1'b0;
      #1;
      if (hold > 0) begin
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf, zero} !== {1'b0, 1'b1, es[0], ec[0], eo[0], ez[0]}) begin
          errors++;
          $display("FAIL hold: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b zero=%b, want 0 1 %h %b %b %b",
                   in_ready, out_valid, sum, cout, ovf, zero, es[0], ec[0], eo[0], ez[0]);
        end
        hold--;
      end else if (out_valid) begin
        checks++;
        if ({sum, cout, ovf, zero} !== {es[got], ec[got], eo[got], ez[got]}) begin
          errors++;
          $display("FAIL stream[%0d]: sum=%h cout=%b ovf=%b zero=%b, want %h %b %b %b",
                   got, sum, cout, ovf, zero, es[got], ec[got], eo[got], ez[got]);
        end
        got++;
      end else if (got > 0) begin
        checks++;
        errors++;
        $display("FAIL stream_gap: out_valid=0 after %0d results, want 1 result/cycle", got);
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 5 || eco !== 4'b0000) begin
      errors++;
      $display("FAIL stream_count: got %0d results, want 5", got);
    end
  endtask
  task automatic test_random;
    int acc = 0, drain = 0, cyc = 0;
    exp_t e;
    while (!(acc >= 10000 && drain >= 8) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (acc >= 10000) begin
        r_in_valid = 1'b0;
        r_out_ready = 1'b1;
        drain++;
      end else begin
        r_in_valid = ($urandom_range(0, 3) != 0);
        r_out_ready = ($urandom_range(0, 3) != 0);
      end
      a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
      r_cin = 1'($urandom); r_sub = 1'($urandom);
      #1;
      if (out_valid8 && r_out_ready) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL rand8_extra: unexpected result sum=%h", sum8);
        end else begin
          e = q8.pop_front();
          if ({sum8, cout8, ovf8, zero8} !== {e.s[7:0], e.co, e.ov, e.z}) begin
            errors++;
            $display("FAIL rand8: sum=%h cout=%b ovf=%b zero=%b, want %h %b %b %b",
                     sum8, cout8, ovf8, zero8, e.s[7:0], e.co, e.ov, e.z);
          end
        end
      end
      if (out_valid32 && r_out_ready) begin
        checks++;
        if (q32.size() == 0) begin
          errors++;
          $display("FAIL rand32_extra: unexpected result sum=%h", sum32);
        end else begin
          e = q32.pop_front();
          if ({sum32, cout32, ovf32, zero32} !== {e.s[31:0], e.co, e.ov, e.z}) begin
            errors++;
            $display("FAIL rand32: sum=%h cout=%b ovf=%b zero=%b, want %h %b %b %b",
                     sum32, cout32, ovf32, zero32, e.s[31:0], e.co, e.ov, e.z);
          end
        end
      end
      if (r_in_valid && in_ready8) begin
        model(8, longint'(a8), longint'(b8), r_cin, r_sub, e.s, e.co, e.ov, e.z);
        q8.push_back(e);
        acc++;
      end
      if (r_in_valid && in_ready32) begin
        model(32, longint'(a32), longint'(b32), r_cin, r_sub, e.s, e.co, e.ov, e.z);
        q32.push_back(e);
      end
    end
    checks++;
    if (acc < 10000 || q8.size() != 0 || q32.size() != 0) begin
      errors++;
      $display("FAIL rand_drain: accepted=%0d pending8=%0d pending32=%0d, want 10000 0 0",
               acc, q8.size(), q32.size());
    end
  endtask
  initial begin
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    r_in_valid = 1'b0; r_out_ready = 1'b1; r_cin = 1'b0; r_sub = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    test_reset;
    test_carry_chain;
    test_overflow;
    test_borrow;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
